// File: rtl/rr_mux4_pkg.sv
// Shared types and select encoding for the
// four-way round-robin mux arbiter.
package rr_mux4_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b11;
  localparam logic [1:0] SEL_D = 2'b10;

  function automatic logic [1:0] idx_to_sel(
    input logic [1:0] idx
  );
    logic [1:0] s;
    unique case (idx)
      2'd0:    s = SEL_A;
      2'd1:    s = SEL_B;
      2'd2:    s = SEL_C;
      default: s = SEL_D;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rr_mux4_arbiter_pick.sv
// Combinational round-robin picker: first set
// candidate bit searching from ptr upward, mod 4.
module rr_pick4 (
  input  logic [3:0] cand,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);

  logic [3:0] rot;
  logic [1:0] off;

  always_comb begin
    rot = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      rot[k] = cand[ptr + 2'(k)];
    end
  end

  // Descending scan so the lowest offset wins.
  always_comb begin
    off = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot[k]) off = 2'(k);
    end
  end

  assign found = |cand;
  assign idx   = ptr + off;

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter driving a 4:1 data mux
// select, one-hot grant and a valid/ready output.
module rr_mux4_arbiter
  import rr_mux4_pkg::*;
#(
  parameter int         W         = 8,
  parameter logic [1:0] RESET_PTR = 2'd0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] in_data,
  input  logic           out_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [3:0]     gnt,
  output logic [3:0]     ack,
  output logic           sel_s1,
  output logic           sel_s2,
  output logic           busy
);

  state_e       state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [1:0]   widx_q, widx_d;
  logic [3:0]   gnt_q, gnt_d;
  logic [1:0]   sel_q, sel_d;
  logic [W-1:0] data_q, data_d;

  logic       xfer;
  logic [3:0] cand;
  logic [1:0] pptr;
  logic       found;
  logic [1:0] pidx;

  assign xfer = (state_q == GRANT) & out_ready;

  // On a transfer the pointer has already moved
  // past the winner, and the winner is masked out.
  assign cand = xfer ? (req & ~gnt_q) : req;
  assign pptr = xfer ? (widx_q + 2'd1) : ptr_q;

  rr_pick4 u_pick (
    .cand  (cand),
    .ptr   (pptr),
    .found (found),
    .idx   (pidx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    widx_d  = widx_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          widx_d  = pidx;
          gnt_d   = 4'b0001 << pidx;
          sel_d   = idx_to_sel(pidx);
          data_d  = in_data[int'(pidx)*W +: W];
        end
      end
      GRANT: begin
        if (xfer) begin
          ptr_d = widx_q + 2'd1;
          if (found) begin
            widx_d = pidx;
            gnt_d  = 4'b0001 << pidx;
            sel_d  = idx_to_sel(pidx);
            data_d = in_data[int'(pidx)*W +: W];
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= RESET_PTR;
      widx_q  <= 2'd0;
      gnt_q   <= 4'b0000;
      sel_q   <= SEL_A;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      widx_q  <= widx_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == GRANT);
  assign busy      = (state_q == GRANT);
  assign out_data  = data_q;
  assign gnt       = gnt_q;
  assign ack       = xfer ? gnt_q : 4'b0000;
  assign sel_s1    = sel_q[1];
  assign sel_s2    = sel_q[0];

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Scoreboard bench for rr_mux4_arbiter: expected
// grants queued at stimulus, checked on transfer.
module tb_rr_mux4_arbiter;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [3:0]     req;
  logic [4*W-1:0] in_data;
  logic           out_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [3:0]     gnt;
  logic [3:0]     ack;
  logic           sel_s1;
  logic           sel_s2;
  logic           busy;

  typedef struct {
    logic [1:0]   idx;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total;
  int   bad;

  rr_mux4_arbiter #(.W(W), .RESET_PTR(2'd0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .gnt       (gnt),
    .ack       (ack),
    .sel_s1    (sel_s1),
    .sel_s2    (sel_s2),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] gray(input logic [1:0] i);
    return {i[1], i[1] ^ i[0]};
  endfunction

  function automatic logic [W-1:0] slice(
    input logic [4*W-1:0] d, input logic [1:0] i
  );
    return d[int'(i)*W +: W];
  endfunction

  task automatic push(input logic [1:0] i);
    exp_t x;
    x.idx  = i;
    x.data = slice(in_data, i);
    sb.push_back(x);
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    req       = 4'b1111;
    out_ready = 1'b1;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({out_valid, out_data, gnt, ack, sel_s1, sel_s2, busy} !== '0) begin
      bad++;
      $display("FAIL reset_hold: v=%b d=%h g=%b a=%b s=%b%b b=%b req 0",
               out_valid, out_data, gnt, ack, sel_s1, sel_s2, busy);
    end
    rst_n     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b1 || gnt !== 4'b0001) begin
      bad++;
      $display("FAIL reset_first_grant: v=%b g=%b req v=1 g=0001",
               out_valid, gnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, gnt, ack, out_data, busy} !== '0) begin
      bad++;
      $display("FAIL reset_async: v=%b g=%b a=%b d=%h b=%b req 0",
               out_valid, gnt, ack, out_data, busy);
    end
  endtask

  task automatic test_single;
    do_reset();
    in_data   = {8'h00, 8'h5A, 8'h00, 8'h00};
    req       = 4'b0100;
    out_ready = 1'b1;
    push(2'd2);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_lat0: v=%b req 0", out_valid);
    end
    @(negedge clk);
    #1;
    e = sb.pop_front();
    total++;
    if (out_valid !== 1'b1 || gnt !== 4'b0100 ||
        {sel_s1, sel_s2} !== 2'b11 || out_data !== 8'h5A ||
        ack !== 4'b0100 || e.data !== 8'h5A) begin
      bad++;
      $display("FAIL single_grant: v=%b g=%b s=%b%b d=%h a=%b req 1 0100 11 5A 0100",
               out_valid, gnt, sel_s1, sel_s2, out_data, ack);
    end
    @(negedge clk);
    req = 4'b0000;
    #1;
    total++;
    if (out_valid !== 1'b0 || gnt !== 4'b0000 || ack !== 4'b0000 ||
        {sel_s1, sel_s2} !== 2'b11 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_idle: v=%b g=%b a=%b s=%b%b b=%b req 0 0000 0000 11 0",
               out_valid, gnt, ack, sel_s1, sel_s2, busy);
    end
    req = 4'b1001;
    @(negedge clk);
    req = 4'b0000;
    #1;
    total++;
    if (gnt !== 4'b1000 || {sel_s1, sel_s2} !== 2'b10) begin
      bad++;
      $display("FAIL single_ptr3: g=%b s=%b%b req 1000 10",
               gnt, sel_s1, sel_s2);
    end
  endtask

  task automatic test_sweep;
    do_reset();
    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req       = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(2'(i));
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 4) req = 4'b1000;
      if (c == 5) req = 4'b0000;
      #1;
      total++;
      if (out_valid !== (c <= 4)) begin
        bad++;
        $display("FAIL sweep_valid c=%0d: v=%b req %b", c, out_valid, c <= 4);
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sweep_extra: g=%b req none", gnt);
        end else begin
          e = sb.pop_front();
          if (gnt !== (4'b0001 << e.idx) || {sel_s1, sel_s2} !== gray(e.idx) ||
              out_data !== e.data || ack !== (4'b0001 << e.idx)) begin
            bad++;
            $display("FAIL sweep_word: g=%b s=%b%b d=%h a=%b req idx %0d d=%h",
                     gnt, sel_s1, sel_s2, out_data, ack, e.idx, e.data);
          end
        end
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sweep_left: %0d words req 0", sb.size());
    end
  endtask

  task automatic test_stall;
    do_reset();
    in_data   = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    req       = 4'b0010;
    out_ready = 1'b0;
    push(2'd1);
    push(2'd2);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      req = 4'b1111;
      #1;
      total++;
      if (out_valid !== 1'b1 || gnt !== 4'b0010 || {sel_s1, sel_s2} !== 2'b01 ||
          out_data !== 8'hB1 || ack !== 4'b0000) begin
        bad++;
        $display("FAIL stall_hold c=%0d: v=%b g=%b s=%b%b d=%h a=%b req 1 0010 01 B1 0000",
                 c, out_valid, gnt, sel_s1, sel_s2, out_data, ack);
      end
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (c == 2) req = 4'b0100;
      if (c == 3) req = 4'b0000;
      #1;
      if (c == 3) begin
        total++;
        if (out_valid !== 1'b0) begin
          bad++;
          $display("FAIL stall_idle: v=%b req 0", out_valid);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL stall_extra: g=%b req none", gnt);
        end else begin
          e = sb.pop_front();
          if (gnt !== (4'b0001 << e.idx) || {sel_s1, sel_s2} !== gray(e.idx) ||
              out_data !== e.data || ack !== (4'b0001 << e.idx)) begin
            bad++;
            $display("FAIL stall_word: g=%b s=%b%b d=%h a=%b req idx %0d d=%h",
                     gnt, sel_s1, sel_s2, out_data, ack, e.idx, e.data);
          end
        end
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL stall_left: %0d words req 0", sb.size());
    end
  endtask

  task automatic test_fairness;
    do_reset();
    in_data   = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    req       = 4'b1001;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(2'd0);
      push(2'd3);
    end
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 8) req = 4'b1000;
      if (c == 9) req = 4'b0000;
      #1;
      if (c == 9) begin
        total++;
        if (out_valid !== 1'b0) begin
          bad++;
          $display("FAIL fair_idle: v=%b req 0", out_valid);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL fair_extra: g=%b req none", gnt);
        end else begin
          e = sb.pop_front();
          if (gnt !== (4'b0001 << e.idx) || {sel_s1, sel_s2} !== gray(e.idx) ||
              out_data !== e.data || ack !== (4'b0001 << e.idx)) begin
            bad++;
            $display("FAIL fair_word: g=%b s=%b%b d=%h a=%b req idx %0d d=%h",
                     gnt, sel_s1, sel_s2, out_data, ack, e.idx, e.data);
          end
        end
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL fair_left: %0d words req 0", sb.size());
    end
  endtask

  task automatic test_reset_release;
    do_reset();
    in_data   = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    req       = 4'b0100;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b1 || gnt !== 4'b0100) begin
      bad++;
      $display("FAIL rel_pre: b=%b g=%b req 1 0100", busy, gnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || ack !== 4'b0000 || gnt !== 4'b0000) begin
      bad++;
      $display("FAIL rel_drop: v=%b a=%b g=%b req 0", out_valid, ack, gnt);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    req       = 4'b1010;
    out_ready = 1'b1;
    push(2'd1);
    push(2'd3);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) req = 4'b1000;
      if (c == 2) req = 4'b0000;
      #1;
      if (c == 3) begin
        total++;
        if (out_valid !== 1'b0) begin
          bad++;
          $display("FAIL rel_idle: v=%b req 0", out_valid);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL rel_extra: g=%b req none", gnt);
        end else begin
          e = sb.pop_front();
          if (gnt !== (4'b0001 << e.idx) || {sel_s1, sel_s2} !== gray(e.idx) ||
              out_data !== e.data || ack !== (4'b0001 << e.idx)) begin
            bad++;
            $display("FAIL rel_word: g=%b s=%b%b d=%h a=%b req idx %0d d=%h",
                     gnt, sel_s1, sel_s2, out_data, ack, e.idx, e.data);
          end
        end
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL rel_left: %0d words req 0", sb.size());
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    in_data   = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_sweep();
    test_stall();
    test_fairness();
    test_reset_release();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
